// File: rtl/dram_bank_timing_monitor.sv
// Passive DRAM command-bus monitor: tracks per-bank row state and elapsed cycles,
// and reports tRCD/tRAS/tRP and protocol violations as a registered pulse plus a counter.
module dram_bank_timing_monitor #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int TRCD      = 3,
  parameter int TRAS      = 7,
  parameter int TRP       = 3,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd,
  input  logic [BANK_W-1:0]    cmd_bank,
  input  logic                 clear_cnt,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 viol_valid,
  output logic [2:0]           viol_code,
  output logic [BANK_W-1:0]    viol_bank,
  output logic [CNT_W-1:0]     viol_cnt
);

  localparam int MAXT = (TRCD > TRAS) ? ((TRCD > TRP) ? TRCD : TRP)
                                      : ((TRAS > TRP) ? TRAS : TRP);
  localparam int TW = $clog2(MAXT + 1);
  localparam logic [TW-1:0] TMAX   = TW'(MAXT);
  localparam logic [TW-1:0] TRCD_C = TW'(TRCD);
  localparam logic [TW-1:0] TRAS_C = TW'(TRAS);
  localparam logic [TW-1:0] TRP_C  = TW'(TRP);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_PRE  = 3'd4;
  localparam logic [2:0] OP_PREA = 3'd5;

  typedef enum logic [1:0] {IDLE, ACTIVE, PRECHG} bank_state_t;

  bank_state_t     state   [NUM_BANKS];
  logic [TW-1:0]   cnt_act [NUM_BANKS];
  logic [TW-1:0]   cnt_pre [NUM_BANKS];

  logic              viol_hit_p0;
  logic [2:0]        viol_code_p0;
  logic [BANK_W-1:0] viol_bank_p0;

  function automatic logic [TW-1:0] tick(input logic [TW-1:0] c);
    return (c >= TMAX) ? TMAX : c + TW'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) bank_open[b] = (state[b] == ACTIVE);
  end

  // p0: classify the command against the state seen this cycle
  always_comb begin
    viol_hit_p0  = 1'b0;
    viol_code_p0 = 3'd0;
    viol_bank_p0 = cmd_bank;
    if (cmd_valid) begin
      case (cmd)
        OP_NOP: ;
        OP_RD, OP_WR: begin
          if (state[cmd_bank] != ACTIVE) begin
            viol_hit_p0  = 1'b1;
            viol_code_p0 = 3'd4;
          end else if (cnt_act[cmd_bank] < TRCD_C) begin
            viol_hit_p0  = 1'b1;
            viol_code_p0 = 3'd1;
          end
        end
        OP_PRE: begin
          if (state[cmd_bank] == ACTIVE && cnt_act[cmd_bank] < TRAS_C) begin
            viol_hit_p0  = 1'b1;
            viol_code_p0 = 3'd2;
          end
        end
        OP_PREA: begin
          // descending scan so the lowest offending bank is the one reported
          for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (state[b] == ACTIVE && cnt_act[b] < TRAS_C) begin
              viol_hit_p0  = 1'b1;
              viol_code_p0 = 3'd2;
              viol_bank_p0 = BANK_W'(b);
            end
          end
        end
        OP_ACT: begin
          if (state[cmd_bank] == ACTIVE) begin
            viol_hit_p0  = 1'b1;
            viol_code_p0 = 3'd5;
          end else if (state[cmd_bank] == PRECHG && cnt_pre[cmd_bank] < TRP_C) begin
            viol_hit_p0  = 1'b1;
            viol_code_p0 = 3'd3;
          end
        end
        default: begin
          viol_hit_p0  = 1'b1;
          viol_code_p0 = 3'd6;
        end
      endcase
    end
  end

  // p1: bank state, counters and registered violation report (rst_n is active-high)
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state[b]   <= IDLE;
        cnt_act[b] <= TMAX;
        cnt_pre[b] <= TMAX;
      end
      viol_valid <= 1'b0;
      viol_code  <= 3'd0;
      viol_bank  <= '0;
      viol_cnt   <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        cnt_act[b] <= tick(cnt_act[b]);
        cnt_pre[b] <= tick(cnt_pre[b]);
        if (state[b] == PRECHG && cnt_pre[b] >= TRP_C) state[b] <= IDLE;
        if (cmd_valid) begin
          if (cmd == OP_ACT && cmd_bank == BANK_W'(b)) begin
            state[b]   <= ACTIVE;
            cnt_act[b] <= TW'(1);
          end else if (state[b] == ACTIVE &&
                       (cmd == OP_PREA || (cmd == OP_PRE && cmd_bank == BANK_W'(b)))) begin
            state[b]   <= PRECHG;
            cnt_pre[b] <= TW'(1);
          end
        end
      end
      viol_valid <= viol_hit_p0;
      if (viol_hit_p0) begin
        viol_code <= viol_code_p0;
        viol_bank <= viol_bank_p0;
      end
      if (clear_cnt)        viol_cnt <= viol_hit_p0 ? CNT_W'(1) : '0;
      else if (viol_hit_p0) viol_cnt <= sat_inc(viol_cnt);
    end
  end

endmodule

// File: tb/tb_dram_bank_timing_monitor.sv
// Directed bench for dram_bank_timing_monitor (4 banks, TRCD=3, TRAS=7, TRP=3, CNT_W=2).
module tb_dram_bank_timing_monitor;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [1:0] cmd_bank;
  logic       clear_cnt;
  logic [3:0] bank_open;
  logic       viol_valid;
  logic [2:0] viol_code;
  logic [1:0] viol_bank;
  logic [1:0] viol_cnt;

  int total = 0;
  int bad   = 0;
  logic seen;

  dram_bank_timing_monitor #(.NUM_BANKS(4), .TRCD(3), .TRAS(7), .TRP(3), .CNT_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
    .clear_cnt(clear_cnt), .bank_open(bank_open), .viol_valid(viol_valid),
    .viol_code(viol_code), .viol_bank(viol_bank), .viol_cnt(viol_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock with the given command presented; returns 1 time unit after the edge
  task automatic step(input logic v, input logic [2:0] c, input logic [1:0] b);
    cmd_valid = v; cmd = c; cmd_bank = b;
    @(posedge clk); #1;
    seen = seen | viol_valid;
    cmd_valid = 1'b0; cmd = 3'd0; cmd_bank = 2'd0;
  endtask

  task automatic nop(input int n);
    repeat (n) step(1'b0, 3'd0, 2'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    seen = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bank_open !== 4'b0) begin bad++; $display("FAIL rst_open got=%b want=0000", bank_open); end
    total++; if (viol_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", viol_valid); end
    total++; if (viol_code !== 3'd0) begin bad++; $display("FAIL rst_code got=%0d want=0", viol_code); end
    total++; if (viol_bank !== 2'd0) begin bad++; $display("FAIL rst_bank got=%0d want=0", viol_bank); end
    total++; if (viol_cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", viol_cnt); end
  endtask

  task automatic test_legal_sequence();
    do_reset();
    step(1'b1, 3'd1, 2'd0);                 // ACT b0 @t0
    total++; if (bank_open[0] !== 1'b1) begin bad++; $display("FAIL legal_open_t1 got=%b want=1", bank_open[0]); end
    nop(2);
    step(1'b1, 3'd2, 2'd0);                 // RD @t0+3, exactly tRCD
    nop(3);
    step(1'b1, 3'd4, 2'd0);                 // PRE @t0+7, exactly tRAS
    total++; if (bank_open[0] !== 1'b0) begin bad++; $display("FAIL legal_open_t8 got=%b want=0", bank_open[0]); end
    nop(2);
    step(1'b1, 3'd1, 2'd0);                 // ACT @t0+10, exactly tRP
    total++; if (bank_open[0] !== 1'b1) begin bad++; $display("FAIL legal_open_t11 got=%b want=1", bank_open[0]); end
    step(1'b1, 3'd4, 2'd2);                 // PRE to idle bank is a legal no-op
    total++; if (bank_open !== 4'b0001) begin bad++; $display("FAIL legal_pre_idle_open got=%b want=0001", bank_open); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL legal_no_viol got=%b want=0", seen); end
    total++; if (viol_cnt !== 2'd0) begin bad++; $display("FAIL legal_cnt got=%0d want=0", viol_cnt); end
  endtask

  task automatic test_trcd();
    do_reset();
    step(1'b1, 3'd1, 2'd1);
    nop(1);
    step(1'b1, 3'd3, 2'd1);                 // WR @t0+2
    total++; if (viol_valid !== 1'b1) begin bad++; $display("FAIL trcd_valid got=%b want=1", viol_valid); end
    total++; if (viol_code !== 3'd1) begin bad++; $display("FAIL trcd_code got=%0d want=1", viol_code); end
    total++; if (viol_bank !== 2'd1) begin bad++; $display("FAIL trcd_bank got=%0d want=1", viol_bank); end
    total++; if (viol_cnt !== 2'd1) begin bad++; $display("FAIL trcd_cnt got=%0d want=1", viol_cnt); end
    nop(1);
    total++; if (viol_valid !== 1'b0) begin bad++; $display("FAIL trcd_pulse_end got=%b want=0", viol_valid); end
    total++; if (viol_code !== 3'd1) begin bad++; $display("FAIL trcd_code_hold got=%0d want=1", viol_code); end
  endtask

  task automatic test_tras_trp();
    do_reset();
    step(1'b1, 3'd1, 2'd2);
    nop(4);
    step(1'b1, 3'd4, 2'd2);                 // PRE @t0+5
    total++; if (viol_valid !== 1'b1 || viol_code !== 3'd2 || viol_bank !== 2'd2) begin
      bad++; $display("FAIL tras_pulse got=%b/%0d/%0d want=1/2/2", viol_valid, viol_code, viol_bank); end
    total++; if (bank_open[2] !== 1'b0) begin bad++; $display("FAIL tras_open got=%b want=0", bank_open[2]); end
    nop(1);
    total++; if (viol_valid !== 1'b0) begin bad++; $display("FAIL tras_pulse_end got=%b want=0", viol_valid); end
    step(1'b1, 3'd1, 2'd2);                 // ACT @t0+7
    total++; if (viol_valid !== 1'b1 || viol_code !== 3'd3 || viol_bank !== 2'd2) begin
      bad++; $display("FAIL trp_pulse got=%b/%0d/%0d want=1/3/2", viol_valid, viol_code, viol_bank); end
    total++; if (bank_open !== 4'b0100) begin bad++; $display("FAIL trp_open got=%b want=0100", bank_open); end
    total++; if (viol_cnt !== 2'd2) begin bad++; $display("FAIL trp_cnt got=%0d want=2", viol_cnt); end
  endtask

  task automatic test_prea();
    do_reset();
    step(1'b1, 3'd1, 2'd0);
    nop(3);
    step(1'b1, 3'd1, 2'd3);                 // ACT b3 @t0+4
    nop(3);
    step(1'b1, 3'd5, 2'd1);                 // PREA @t0+8
    total++; if (viol_valid !== 1'b1 || viol_code !== 3'd2 || viol_bank !== 2'd3) begin
      bad++; $display("FAIL prea_pulse got=%b/%0d/%0d want=1/2/3", viol_valid, viol_code, viol_bank); end
    total++; if (bank_open !== 4'b0000) begin bad++; $display("FAIL prea_open got=%b want=0000", bank_open); end
    nop(1);
    total++; if (viol_valid !== 1'b0 || viol_cnt !== 2'd1) begin
      bad++; $display("FAIL prea_single got=%b/%0d want=0/1", viol_valid, viol_cnt); end
    do_reset();
    step(1'b1, 3'd1, 2'd2);
    step(1'b1, 3'd1, 2'd1);
    step(1'b1, 3'd5, 2'd3);                 // both b1 and b2 too young
    total++; if (viol_code !== 3'd2 || viol_bank !== 2'd1) begin
      bad++; $display("FAIL prea_lowest got=%0d/%0d want=2/1", viol_code, viol_bank); end
  endtask

  task automatic test_protocol();
    do_reset();
    step(1'b1, 3'd2, 2'd1);                 // RD to idle bank
    total++; if (viol_valid !== 1'b1 || viol_code !== 3'd4 || viol_bank !== 2'd1) begin
      bad++; $display("FAIL closed_row got=%b/%0d/%0d want=1/4/1", viol_valid, viol_code, viol_bank); end
    step(1'b1, 3'd1, 2'd1);
    total++; if (viol_valid !== 1'b0) begin bad++; $display("FAIL first_act got=%b want=0", viol_valid); end
    step(1'b1, 3'd1, 2'd1);
    total++; if (viol_valid !== 1'b1 || viol_code !== 3'd5 || viol_bank !== 2'd1) begin
      bad++; $display("FAIL double_act got=%b/%0d/%0d want=1/5/1", viol_valid, viol_code, viol_bank); end
    step(1'b1, 3'd7, 2'd2);
    total++; if (viol_valid !== 1'b1 || viol_code !== 3'd6 || viol_bank !== 2'd2) begin
      bad++; $display("FAIL illegal got=%b/%0d/%0d want=1/6/2", viol_valid, viol_code, viol_bank); end
    total++; if (bank_open !== 4'b0010) begin bad++; $display("FAIL illegal_open got=%b want=0010", bank_open); end
    step(1'b0, 3'd7, 2'd0);                 // not valid: never checked
    total++; if (viol_valid !== 1'b0 || viol_cnt !== 2'd3) begin
      bad++; $display("FAIL invalid_cmd got=%b/%0d want=0/3", viol_valid, viol_cnt); end
  endtask

  task automatic test_counter_and_reset();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'd6, 2'd0);
      total++; if (viol_cnt !== exp_cnt[i]) begin
        bad++; $display("FAIL sat_cnt_%0d got=%0d want=%0d", i, viol_cnt, exp_cnt[i]); end
    end
    clear_cnt = 1'b1;
    step(1'b1, 3'd6, 2'd0);
    total++; if (viol_cnt !== 2'd1) begin bad++; $display("FAIL clear_with_viol got=%0d want=1", viol_cnt); end
    nop(1);
    clear_cnt = 1'b0;
    total++; if (viol_cnt !== 2'd0) begin bad++; $display("FAIL clear_alone got=%0d want=0", viol_cnt); end
    step(1'b1, 3'd1, 2'd0);
    step(1'b1, 3'd7, 2'd3);
    #2 rst_n = 1'b1;                        // asynchronous, mid-cycle
    #1;
    total++; if (bank_open !== 4'b0 || viol_valid !== 1'b0 || viol_code !== 3'd0 ||
                 viol_bank !== 2'd0 || viol_cnt !== 2'd0) begin
      bad++; $display("FAIL async_rst got=%b/%b/%0d/%0d/%0d want=0000/0/0/0/0",
                      bank_open, viol_valid, viol_code, viol_bank, viol_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    nop(2);
    total++; if (viol_valid !== 1'b0 || viol_cnt !== 2'd0) begin
      bad++; $display("FAIL post_rst_pending got=%b/%0d want=0/0", viol_valid, viol_cnt); end
    step(1'b1, 3'd1, 2'd3);                 // ACT legal right after reset
    total++; if (viol_valid !== 1'b0 || bank_open !== 4'b1000) begin
      bad++; $display("FAIL post_rst_act got=%b/%b want=0/1000", viol_valid, bank_open); end
  endtask

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; cmd_bank = 2'd0; clear_cnt = 1'b0; seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_legal_sequence();
    test_trcd();
    test_tras_trp();
    test_prea();
    test_protocol();
    test_counter_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
